// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the instruction-fetch / load-store memory arbiter.
package mem_arbiter_pkg;

  // Arbiter FSM states: idle, fetch transaction in flight, data transaction in flight.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DATA  = 2'd2
  } arb_state_e;

  // Byte enables used for every read and every fetch.
  localparam logic [3:0] MEM_BE_ALL = 4'b1111;

  // Width of the consecutive-data-grant counter.
  localparam int STREAK_W = 4;

  // Saturating increment so the streak counter can never wrap back to zero.
  function automatic logic [STREAK_W-1:0] streak_inc(input logic [STREAK_W-1:0] v);
    if (v == {STREAK_W{1'b1}}) begin
      streak_inc = v;
    end else begin
      streak_inc = v + {{(STREAK_W-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between an instruction fetch port and a load/store
// port. Data has priority, but a waiting fetch is guaranteed a grant after
// MAX_DATA_STREAK consecutive data grants. All outputs are registered.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_DATA_STREAK = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_req,
  input  logic [29:0] fetch_addr,
  input  logic        fetch_flush,
  output logic        fetch_ack,
  output logic [31:0] fetch_rdata,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [29:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_be,
  output logic        data_ack,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam logic [STREAK_W-1:0] MAX_STREAK = STREAK_W'(MAX_DATA_STREAK);

  arb_state_e          r_state,       w_state_nxt;
  logic                r_mem_req,     w_mem_req_nxt;
  logic                r_mem_we,      w_mem_we_nxt;
  logic [29:0]         r_mem_addr,    w_mem_addr_nxt;
  logic [31:0]         r_mem_wdata,   w_mem_wdata_nxt;
  logic [3:0]          r_mem_be,      w_mem_be_nxt;
  logic                r_fetch_ack,   w_fetch_ack_nxt;
  logic                r_data_ack,    w_data_ack_nxt;
  logic [31:0]         r_fetch_rdata, w_fetch_rdata_nxt;
  logic [31:0]         r_data_rdata,  w_data_rdata_nxt;
  logic [STREAK_W-1:0] r_streak,      w_streak_nxt;
  logic                r_drop,        w_drop_nxt;
  logic                r_busy,        w_busy_nxt;
  logic                w_fetch_wins;

  // A flushed fetch is not eligible; otherwise fetch wins when data is absent or the streak limit is hit.
  assign w_fetch_wins = fetch_req & ~fetch_flush & (~data_req | (r_streak >= MAX_STREAK));

  // Next-state and next-output logic for the arbiter FSM and streak counter.
  always_comb begin
    w_state_nxt       = r_state;
    w_mem_req_nxt     = r_mem_req;
    w_mem_we_nxt      = r_mem_we;
    w_mem_addr_nxt    = r_mem_addr;
    w_mem_wdata_nxt   = r_mem_wdata;
    w_mem_be_nxt      = r_mem_be;
    w_fetch_ack_nxt   = 1'b0;
    w_data_ack_nxt    = 1'b0;
    w_fetch_rdata_nxt = r_fetch_rdata;
    w_data_rdata_nxt  = r_data_rdata;
    w_streak_nxt      = r_streak;
    w_drop_nxt        = r_drop;
    case (r_state)
      ST_IDLE: begin
        if (w_fetch_wins) begin
          w_state_nxt     = ST_FETCH;
          w_mem_req_nxt   = 1'b1;
          w_mem_we_nxt    = 1'b0;
          w_mem_addr_nxt  = fetch_addr;
          w_mem_wdata_nxt = 32'h0000_0000;
          w_mem_be_nxt    = MEM_BE_ALL;
          w_streak_nxt    = {STREAK_W{1'b0}};
          w_drop_nxt      = 1'b0;
        end else if (data_req) begin
          w_state_nxt     = ST_DATA;
          w_mem_req_nxt   = 1'b1;
          w_mem_we_nxt    = data_we;
          w_mem_addr_nxt  = data_addr;
          w_mem_wdata_nxt = data_wdata;
          w_mem_be_nxt    = data_we ? data_be : MEM_BE_ALL;
          // Only data grants that make a fetch wait count towards the streak.
          if (fetch_req) begin
            w_streak_nxt = streak_inc(r_streak);
          end else begin
            w_streak_nxt = {STREAK_W{1'b0}};
          end
        end else if (!fetch_req) begin
          w_streak_nxt = {STREAK_W{1'b0}};
        end else begin
          w_streak_nxt = r_streak;
        end
      end
      ST_FETCH: begin
        if (mem_ack) begin
          w_state_nxt   = ST_IDLE;
          w_mem_req_nxt = 1'b0;
          w_drop_nxt    = 1'b0;
          // A flush seen at any point of the transaction, including the ack cycle, kills the ack.
          if (!(r_drop || fetch_flush)) begin
            w_fetch_ack_nxt   = 1'b1;
            w_fetch_rdata_nxt = mem_rdata;
          end else begin
            w_fetch_ack_nxt   = 1'b0;
          end
        end else if (fetch_flush) begin
          w_drop_nxt = 1'b1;
        end else begin
          w_drop_nxt = r_drop;
        end
      end
      ST_DATA: begin
        if (mem_ack) begin
          w_state_nxt      = ST_IDLE;
          w_mem_req_nxt    = 1'b0;
          w_data_ack_nxt   = 1'b1;
          w_data_rdata_nxt = mem_rdata;
        end else begin
          w_state_nxt = r_state;
        end
      end
      default: begin
        w_state_nxt   = ST_IDLE;
        w_mem_req_nxt = 1'b0;
      end
    endcase
    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  // State, memory-side and requester-side registers; reset abandons any transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_mem_req     <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= 30'h0;
      r_mem_wdata   <= 32'h0000_0000;
      r_mem_be      <= MEM_BE_ALL;
      r_fetch_ack   <= 1'b0;
      r_data_ack    <= 1'b0;
      r_fetch_rdata <= 32'h0000_0000;
      r_data_rdata  <= 32'h0000_0000;
      r_streak      <= {STREAK_W{1'b0}};
      r_drop        <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_mem_req     <= w_mem_req_nxt;
      r_mem_we      <= w_mem_we_nxt;
      r_mem_addr    <= w_mem_addr_nxt;
      r_mem_wdata   <= w_mem_wdata_nxt;
      r_mem_be      <= w_mem_be_nxt;
      r_fetch_ack   <= w_fetch_ack_nxt;
      r_data_ack    <= w_data_ack_nxt;
      r_fetch_rdata <= w_fetch_rdata_nxt;
      r_data_rdata  <= w_data_rdata_nxt;
      r_streak      <= w_streak_nxt;
      r_drop        <= w_drop_nxt;
      r_busy        <= w_busy_nxt;
    end
  end

  assign mem_req     = r_mem_req;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign mem_be      = r_mem_be;
  assign fetch_ack   = r_fetch_ack;
  assign fetch_rdata = r_fetch_rdata;
  assign data_ack    = r_data_ack;
  assign data_rdata  = r_data_rdata;
  assign busy        = r_busy;

endmodule
